// File: rtl/mac_row_sequencer.sv
// Control sequencer for the per-row HLS MAC cores: launches every core via ap_ctrl_hs,
// collects one 32-bit result per row and reports completion, timeout and cycle usage.
module mac_row_sequencer #(
  parameter int NUM_ROWS    = 5,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout,
  output logic [CNT_W-1:0]         cycles,
  output logic [NUM_ROWS-1:0]      row_valid,
  input  logic [2:0]               rd_addr,
  output logic [31:0]              rd_data,
  output logic [NUM_ROWS-1:0]      ap_start,
  input  logic [NUM_ROWS-1:0]      ap_ready,
  input  logic [NUM_ROWS-1:0]      ap_done,
  input  logic [NUM_ROWS-1:0]      ap_idle,
  input  logic [32*NUM_ROWS-1:0]   y_o,
  input  logic [NUM_ROWS-1:0]      y_o_ap_vld
);

  typedef enum logic [2:0] {IDLE, WAIT_IDLE, LAUNCH, WAIT_DONE, FINISH} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t                state_reg, state_next;
  logic                  accept, launch, tmo_hit, active, all_done, cnt_hit;
  logic [CNT_W-1:0]      cnt_reg;
  logic                  tmo_reg;
  logic [NUM_ROWS-1:0]   start_reg, pending_reg, done_seen_reg, row_valid_reg;
  logic [31:0]           result_reg [NUM_ROWS];
  logic [31:0]           rd_view [8];
  logic [31:0]           rd_data_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // A done arriving this cycle counts, so the run can finish without an extra wait cycle.
  assign all_done = &(done_seen_reg | ap_done);
  assign cnt_hit  = (cnt_reg == TIMEOUT_VAL);

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    launch     = 1'b0;
    tmo_hit    = 1'b0;
    active     = (state_reg == WAIT_IDLE) || (state_reg == LAUNCH) || (state_reg == WAIT_DONE);
    case (state_reg)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = (&ap_idle) ? LAUNCH : WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (cnt_hit) begin
          tmo_hit    = 1'b1;
          state_next = FINISH;
        end else if (&ap_idle) begin
          state_next = LAUNCH;
        end
      end
      LAUNCH: begin
        if (cnt_hit) begin
          tmo_hit    = 1'b1;
          state_next = FINISH;
        end else begin
          launch     = 1'b1;
          state_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (cnt_hit) begin
          tmo_hit    = 1'b1;
          state_next = FINISH;
        end else if (all_done && (start_reg == '0)) begin
          state_next = FINISH;
        end
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Counter freezes on the value that triggered the timeout so cycles reads TIMEOUT_CYC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
      tmo_reg <= 1'b0;
    end else begin
      if (accept) begin
        cnt_reg <= '0;
        tmo_reg <= 1'b0;
      end else if (active && !cnt_hit && (cnt_reg != CNT_MAX)) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      if (tmo_hit) tmo_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_reg     <= '0;
      pending_reg   <= '0;
      done_seen_reg <= '0;
      row_valid_reg <= '0;
      for (int i = 0; i < NUM_ROWS; i++) result_reg[i] <= '0;
    end else begin
      if (state_reg == IDLE) begin
        if (accept) begin
          done_seen_reg <= '0;
          row_valid_reg <= '0;
        end
      end else begin
        for (int i = 0; i < NUM_ROWS; i++) begin
          if (y_o_ap_vld[i]) begin
            result_reg[i]    <= y_o[32*i +: 32];
            row_valid_reg[i] <= 1'b1;
          end
        end
      end
      if (state_reg == WAIT_DONE) done_seen_reg <= done_seen_reg | ap_done;
      if (launch) begin
        start_reg   <= '1;
        pending_reg <= '1;
      end else if (tmo_hit) begin
        start_reg   <= '0;
        pending_reg <= '0;
      end else if (state_reg == WAIT_DONE) begin
        start_reg   <= start_reg & ~(pending_reg & ap_ready);
        pending_reg <= pending_reg & ~ap_ready;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_rd
      if (gi < NUM_ROWS) begin : g_row
        assign rd_view[gi] = result_reg[gi];
      end else begin : g_pad
        assign rd_view[gi] = '0;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_reg <= '0;
    else        rd_data_reg <= rd_view[rd_addr];
  end

  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == FINISH);
  assign timeout   = tmo_reg;
  assign cycles    = cnt_reg;
  assign row_valid = row_valid_reg;
  assign ap_start  = start_reg;
  assign rd_data   = rd_data_reg;

endmodule

// File: tb/tb_mac_row_sequencer.sv
// Bench for mac_row_sequencer: table of runs driven through a small MAC-core model,
// results checked through a read-back scoreboard queue.
module tb_mac_row_sequencer;

  localparam int NR = 5;

  logic            clk, rst_n, start;
  logic            busy, done, timeout;
  logic [15:0]     cycles;
  logic [NR-1:0]   row_valid, ap_start, ap_ready, ap_done, ap_idle, y_o_ap_vld;
  logic [2:0]      rd_addr;
  logic [31:0]     rd_data;
  logic [32*NR-1:0] y_o;

  mac_row_sequencer #(.NUM_ROWS(NR), .CNT_W(16), .TIMEOUT_CYC(20)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .timeout(timeout), .cycles(cycles), .row_valid(row_valid),
    .rd_addr(rd_addr), .rd_data(rd_data), .ap_start(ap_start),
    .ap_ready(ap_ready), .ap_done(ap_done), .ap_idle(ap_idle),
    .y_o(y_o), .y_o_ap_vld(y_o_ap_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        do_reset;
    int          idle_wait;
    logic [4:0]  ready_mask;
    logic [4:0]  done_mask;
    logic [4:0]  vld_mask;
    logic [31:0] base;
    logic        hs_edge;
    int          extra_start;
    int          rise_cyc;
    int          done_cyc;
    int          hi0;
    int          hi4;
    logic [15:0] exp_cyc;
    logic [4:0]  exp_rv;
    logic        exp_tmo;
  } case_t;

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] data;
  } rd_exp_t;

  case_t       cases [6];
  rd_exp_t     rd_q [$];
  logic [31:0] exp_result [NR];
  int          checks = 0;
  int          errors = 0;
  int          cur_case = -1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (case %0d): got 0x%0h expected 0x%0h", nm, cur_case, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start = 1'b0; ap_ready = '0; ap_done = '0; y_o_ap_vld = '0; y_o = '0;
    ap_idle = '1; rd_addr = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < NR; i++) exp_result[i] = '0;
  endtask

  task automatic run_case(input case_t c);
    int rise, done_at, done_cnt;
    int hi [NR];
    logic [NR-1:0] start_at_done;
    logic [31:0] v;
    rise = -1; done_at = -1; done_cnt = 0; start_at_done = '1;
    for (int i = 0; i < NR; i++) hi[i] = 0;
    for (int n = 0; n <= c.done_cyc + 3; n++) begin
      if (ap_start != '0 && rise < 0) rise = n;
      for (int i = 0; i < NR; i++) if (ap_start[i]) hi[i]++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) begin done_at = n; start_at_done = ap_start; end
      end
      clear_inputs();
      start = (n == 0) || (n == c.extra_start);
      if (n < c.idle_wait) ap_idle[2] = 1'b0;
      if (rise >= 0) begin
        for (int i = 0; i < NR; i++) begin
          if (c.ready_mask[i] && ap_start[i] &&
              n == rise + ((c.hs_edge && i == 0) ? 4 : 1)) ap_ready[i] = 1'b1;
          if (c.hs_edge && i == 0 && n == rise + 2) begin
            y_o_ap_vld[i] = 1'b1; y_o[32*i +: 32] = 32'h55; exp_result[i] = 32'h55;
          end
          if (c.done_mask[i] && n == rise + 4 + i) begin
            ap_done[i] = 1'b1;
            if (c.vld_mask[i]) begin
              v = (c.hs_edge && i == 0) ? 32'hAA : c.base + 32'(i);
              y_o_ap_vld[i] = 1'b1; y_o[32*i +: 32] = v; exp_result[i] = v;
            end
          end
        end
      end
      tick();
    end
    clear_inputs();
    chk("start_rise_cycle", 32'(rise), 32'(c.rise_cyc));
    chk("done_cycle", 32'(done_at), 32'(c.done_cyc));
    chk("done_pulse_count", 32'(done_cnt), 32'd1);
    chk("ap_start_hi_row0", 32'(hi[0]), 32'(c.hi0));
    chk("ap_start_hi_row4", 32'(hi[4]), 32'(c.hi4));
    chk("ap_start_at_done", 32'(start_at_done), 32'd0);
    chk("busy_after", 32'(busy), 32'd0);
    chk("row_valid", 32'(row_valid), 32'(c.exp_rv));
    chk("timeout", 32'(timeout), 32'(c.exp_tmo));
    chk("cycles", 32'(cycles), 32'(c.exp_cyc));
    for (int a = 0; a < 8; a++) begin
      rd_exp_t e;
      rd_addr = 3'(a);
      e.addr = 3'(a);
      e.data = (a < NR) ? exp_result[a] : 32'd0;
      rd_q.push_back(e);
      tick();
      e = rd_q.pop_front();
      chk($sformatf("rd_data[%0d]", e.addr), rd_data, e.data);
    end
    $display("case %0d: start rise %0d, done at %0d, cycles=%0d row_valid=%b timeout=%0d",
             cur_case, rise, done_at, cycles, row_valid, timeout);
  endtask

  task automatic async_reset_seq();
    clear_inputs();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    y_o_ap_vld[0] = 1'b1; y_o[31:0] = 32'h77;
    tick();
    clear_inputs();
    chk("pre_reset_ap_start", 32'(ap_start), 32'h1f);
    chk("pre_reset_row_valid", 32'(row_valid), 32'h01);
    #2 rst_n = 1'b0;
    #1;
    chk("async_ap_start", 32'(ap_start), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_row_valid", 32'(row_valid), 32'd0);
    $display("async reset: ap_start=%b busy=%0d row_valid=%b", ap_start, busy, row_valid);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < NR; i++) exp_result[i] = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //           rst  iw  rdy    done   vld    base    hs  xs  rise done hi0 hi4 cyc   rv     tmo
    cases[0] = '{1'b1, 0, 5'h1f, 5'h1f, 5'h1f, 32'h10, 1'b0, -1, 2, 11, 2, 2, 16'd10, 5'h1f, 1'b0};
    cases[1] = '{1'b0, 4, 5'h1f, 5'h1f, 5'h1f, 32'h20, 1'b0, -1, 6, 15, 2, 2, 16'd14, 5'h1f, 1'b0};
    cases[2] = '{1'b1, 0, 5'h1f, 5'h1f, 5'h1d, 32'h30, 1'b0, -1, 2, 11, 2, 2, 16'd10, 5'h1d, 1'b0};
    cases[3] = '{1'b0, 0, 5'h0f, 5'h0f, 5'h0f, 32'h40, 1'b0, -1, 2, 22, 2, 20, 16'd20, 5'h0f, 1'b1};
    cases[4] = '{1'b0, 0, 5'h1f, 5'h1f, 5'h1f, 32'h50, 1'b1, 3, 2, 11, 5, 2, 16'd10, 5'h1f, 1'b0};
    cases[5] = '{1'b0, 0, 5'h1f, 5'h1f, 5'h1f, 32'h60, 1'b0, -1, 2, 11, 2, 2, 16'd10, 5'h1f, 1'b0};

    clear_inputs();
    rst_n = 1'b0;
    for (int i = 0; i < NR; i++) exp_result[i] = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_timeout", 32'(timeout), 32'd0);
    chk("reset_cycles", 32'(cycles), 32'd0);
    chk("reset_row_valid", 32'(row_valid), 32'd0);
    chk("reset_ap_start", 32'(ap_start), 32'd0);
    chk("reset_rd_data", rd_data, 32'd0);
    rst_n = 1'b1;
    tick();

    for (int k = 0; k < 6; k++) begin
      cur_case = k;
      if (k == 5) async_reset_seq();
      if (cases[k].do_reset) do_reset();
      run_case(cases[k]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
